// File: rtl/data_mem_unit.sv
// Load/store unit between the memory stage and a word-wide request/response bus.
// Unaligned accesses become two word transactions when SPLIT_MISALIGNED = 1.
module data_mem_unit #(
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memu_cmd_start,
  input  logic        memu_cmd_write,
  output logic        memu_cmd_ready,
  input  logic [31:0] memu_addr,
  input  logic [31:0] memu_wdata,
  input  logic [31:0] memu_wmask,
  output logic        memu_valid,
  output logic [31:0] memu_rdata,
  output logic        dreq_valid,
  input  logic        dreq_ready,
  output logic        dreq_write,
  output logic [31:0] dreq_addr,
  output logic [31:0] dreq_wdata,
  output logic [3:0]  dreq_wstrb,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_rdata,
  output logic [2:0]  dbg_state
);
  // Handshakes: a command transfers on a rising edge with memu_cmd_start and
  // memu_cmd_ready both high; a bus request transfers on a rising edge with
  // dreq_valid and dreq_ready both high, and every dreq_* output holds steady
  // until then. Responses are only consumed in RESP0/RESP1.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    RESP0 = 3'd2,
    REQ1  = 3'd3,
    RESP1 = 3'd4
  } state_t;

  state_t      state, state_nxt;

  logic        write_q;
  logic [1:0]  off_q;
  logic [31:0] word0_q;
  logic [7:0]  strb_q;
  logic [63:0] data_q;
  logic [31:0] rdata0_q;

  logic        accept;
  logic        need_second;
  logic        load_done;
  logic [7:0]  size_strb;
  logic [31:0] word1;
  logic [63:0] load_cat;
  logic [31:0] load_shift;

  assign accept      = memu_cmd_ready && memu_cmd_start;
  assign word1       = word0_q + 32'd4;
  assign need_second = (SPLIT_MISALIGNED != 0) &&
                       (write_q ? (strb_q[7:4] != 4'b0000) : (off_q != 2'b00));

  always_comb begin
    size_strb = 8'b0000_1111;
    if (memu_wmask == 32'h0000_00ff)
      size_strb = 8'b0000_0001;
    else if (memu_wmask == 32'h0000_ffff)
      size_strb = 8'b0000_0011;
  end

  // Second word supplies the high bytes; the first word is shifted down by off.
  assign load_cat   = (state == RESP1) ? {dresp_rdata, rdata0_q} : {32'b0, dresp_rdata};
  assign load_shift = 32'(load_cat >> {off_q, 3'b000});
  assign load_done  = !write_q && dresp_valid &&
                      (((state == RESP0) && !need_second) || (state == RESP1));

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ0;
      REQ0:    if (dreq_ready) state_nxt = RESP0;
      RESP0:   if (dresp_valid) state_nxt = need_second ? REQ1 : IDLE;
      REQ1:    if (dreq_ready) state_nxt = RESP1;
      RESP1:   if (dresp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    memu_cmd_ready = (state == IDLE);
    dbg_state      = state;
    dreq_valid     = 1'b0;
    dreq_write     = 1'b0;
    dreq_addr      = 32'b0;
    dreq_wdata     = 32'b0;
    dreq_wstrb     = 4'b0000;
    case (state)
      REQ0: begin
        dreq_valid = 1'b1;
        dreq_write = write_q;
        dreq_addr  = word0_q;
        dreq_wdata = write_q ? data_q[31:0] : 32'b0;
        dreq_wstrb = write_q ? strb_q[3:0] : 4'b0000;
      end
      REQ1: begin
        dreq_valid = 1'b1;
        dreq_write = write_q;
        dreq_addr  = word1;
        dreq_wdata = write_q ? data_q[63:32] : 32'b0;
        dreq_wstrb = write_q ? strb_q[7:4] : 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q    <= 1'b0;
      off_q      <= 2'b00;
      word0_q    <= 32'b0;
      strb_q     <= 8'b0;
      data_q     <= 64'b0;
      rdata0_q   <= 32'b0;
      memu_valid <= 1'b0;
      memu_rdata <= 32'b0;
    end else begin
      memu_valid <= 1'b0;
      if (accept) begin
        write_q <= memu_cmd_write;
        off_q   <= memu_addr[1:0];
        word0_q <= {memu_addr[31:2], 2'b00};
        strb_q  <= size_strb << memu_addr[1:0];
        data_q  <= {32'b0, memu_wdata} << {memu_addr[1:0], 3'b000};
      end
      if ((state == RESP0) && dresp_valid)
        rdata0_q <= dresp_rdata;
      if (load_done) begin
        memu_valid <= 1'b1;
        memu_rdata <= load_shift;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized bench for data_mem_unit: byte-level memory reference model,
// bus responder with stalls, and a scoreboard for bus requests and load data.
module tb_data_mem_unit;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RESP1 = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // split DUT
  logic        memu_cmd_start, memu_cmd_write, memu_cmd_ready;
  logic [31:0] memu_addr, memu_wdata, memu_wmask;
  logic        memu_valid;
  logic [31:0] memu_rdata;
  logic        dreq_valid, dreq_ready, dreq_write;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic [2:0]  dbg_state;

  // no-split DUT
  logic        ns_cmd_start, ns_cmd_write, ns_cmd_ready;
  logic [31:0] ns_addr, ns_wdata, ns_wmask;
  logic        ns_valid;
  logic [31:0] ns_rdata;
  logic        ns_dreq_valid, ns_dreq_ready, ns_dreq_write;
  logic [31:0] ns_dreq_addr, ns_dreq_wdata;
  logic [3:0]  ns_dreq_wstrb;
  logic        ns_dresp_valid;
  logic [31:0] ns_dresp_rdata;
  logic [2:0]  ns_dbg_state;

  data_mem_unit #(.SPLIT_MISALIGNED(1)) u_dut (
    .clk(clk), .reset(reset),
    .memu_cmd_start(memu_cmd_start), .memu_cmd_write(memu_cmd_write),
    .memu_cmd_ready(memu_cmd_ready), .memu_addr(memu_addr),
    .memu_wdata(memu_wdata), .memu_wmask(memu_wmask),
    .memu_valid(memu_valid), .memu_rdata(memu_rdata),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_write(dreq_write),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .dbg_state(dbg_state)
  );

  data_mem_unit #(.SPLIT_MISALIGNED(0)) u_dut_ns (
    .clk(clk), .reset(reset),
    .memu_cmd_start(ns_cmd_start), .memu_cmd_write(ns_cmd_write),
    .memu_cmd_ready(ns_cmd_ready), .memu_addr(ns_addr),
    .memu_wdata(ns_wdata), .memu_wmask(ns_wmask),
    .memu_valid(ns_valid), .memu_rdata(ns_rdata),
    .dreq_valid(ns_dreq_valid), .dreq_ready(ns_dreq_ready), .dreq_write(ns_dreq_write),
    .dreq_addr(ns_dreq_addr), .dreq_wdata(ns_dreq_wdata), .dreq_wstrb(ns_dreq_wstrb),
    .dresp_valid(ns_dresp_valid), .dresp_rdata(ns_dresp_rdata), .dbg_state(ns_dbg_state)
  );

  // scoreboard state
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_txn_t;

  bus_txn_t    bus_exp_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem[bit [31:0]];
  logic [7:0]  bus_mem[bit [31:0]];
  logic [31:0] last_load;
  int          checks = 0;
  int          passes = 0;

  // responder knobs
  int          force_stall = -1;
  logic        hold_resp   = 1'b0;
  logic        stray_resp  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return 8'((a * 32'd13) + 32'd7);
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] rd_bus(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      ref_mem[a + 32'(i)] = v[8*i +: 8];
      bus_mem[a + 32'(i)] = v[8*i +: 8];
    end
  endtask

  // Reference model: an access touches n consecutive bytes starting at addr;
  // each byte lands in whichever aligned word contains it.
  task automatic model_cmd(input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [31:0] wm);
    logic [31:0] w0, ba, ld;
    bus_txn_t    t0, t1;
    int          n;
    w0 = {a[31:2], 2'b00};
    t0 = '{w0, w, 4'b0000, 32'b0};
    t1 = '{w0 + 32'd4, w, 4'b0000, 32'b0};
    if (w) begin
      n = (wm == 32'h0000_00ff) ? 1 : (wm == 32'h0000_ffff) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
        ba = a + 32'(i);
        ref_mem[ba] = wd[8*i +: 8];
        if ({ba[31:2], 2'b00} == w0) begin
          t0.strb[ba[1:0]] = 1'b1;
          t0.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
        end else begin
          t1.strb[ba[1:0]] = 1'b1;
          t1.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
        end
      end
      bus_exp_q.push_back(t0);
      if (t1.strb != 4'b0000) bus_exp_q.push_back(t1);
    end else begin
      ld = 32'b0;
      for (int i = 0; i < 4; i++) ld[8*i +: 8] = rd_ref(a + 32'(i));
      exp_q.push_back(ld);
      bus_exp_q.push_back(t0);
      if (a[1:0] != 2'b00) bus_exp_q.push_back(t1);
    end
  endtask

  // driver: called at a negedge, returns at a negedge after acceptance
  task automatic issue(input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [31:0] wm);
    int cyc;
    cyc = 0;
    while (!memu_cmd_ready && cyc < 300) begin
      memu_cmd_start = 1'($urandom_range(0, 1));
      memu_addr      = $urandom;
      memu_cmd_write = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    if (!memu_cmd_ready) begin
      check("cmd_ready_timeout", 32'(memu_cmd_ready), 32'd1);
      memu_cmd_start = 1'b0;
      return;
    end
    if (!memu_valid) check("rdata_hold", memu_rdata, last_load);
    model_cmd(a, w, wd, wm);
    memu_cmd_start = 1'b1;
    memu_cmd_write = w;
    memu_addr      = a;
    memu_wdata     = wd;
    memu_wmask     = wm;
    @(negedge clk);
    memu_cmd_start = 1'b0;
    memu_cmd_write = 1'($urandom_range(0, 1));
    memu_addr      = $urandom;
    memu_wdata     = $urandom;
    memu_wmask     = $urandom;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (!(memu_cmd_ready && exp_q.size() == 0 && bus_exp_q.size() == 0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) check("wait_idle_timeout", 32'(exp_q.size() + bus_exp_q.size()), 32'd0);
  endtask

  // bus responder for the split DUT
  logic        pend, seen_req;
  logic [31:0] pend_data, saved_addr, saved_wdata;
  int          resp_delay, stall_left;

  task automatic accept_bus();
    bus_txn_t    t;
    logic [31:0] mask;
    if (bus_exp_q.size() == 0) begin
      check("bus_unexpected_req", 32'(dreq_valid), 32'd0);
    end else begin
      t = bus_exp_q.pop_front();
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{t.strb[i]}};
      check("bus_addr", dreq_addr, t.addr);
      check("bus_write", 32'(dreq_write), 32'(t.write));
      check("bus_wstrb", 32'(dreq_wstrb), 32'(t.strb));
      if (t.write) check("bus_wdata", dreq_wdata & mask, t.wdata);
    end
    check("bus_stable_addr", dreq_addr, saved_addr);
    check("bus_stable_wdata", dreq_wdata, saved_wdata);
    if (dreq_write)
      for (int i = 0; i < 4; i++)
        if (dreq_wstrb[i]) bus_mem[dreq_addr + 32'(i)] = dreq_wdata[8*i +: 8];
    for (int i = 0; i < 4; i++) pend_data[8*i +: 8] = rd_bus(dreq_addr + 32'(i));
    resp_delay = $urandom_range(0, 2);
    pend = 1'b1;
  endtask

  initial begin
    dreq_ready  = 1'b0;
    dresp_valid = 1'b0;
    dresp_rdata = 32'b0;
    pend        = 1'b0;
    seen_req    = 1'b0;
    forever begin
      @(negedge clk);
      dresp_valid = 1'b0;
      if (pend && dbg_state == ST_IDLE) pend = 1'b0;
      if (stray_resp && dbg_state == ST_IDLE) begin
        dresp_valid = 1'b1;
        dresp_rdata = $urandom;
      end else if (pend) begin
        if (resp_delay > 0) resp_delay--;
        else if (!(hold_resp && dbg_state == ST_RESP1)) begin
          dresp_valid = 1'b1;
          dresp_rdata = pend_data;
          pend = 1'b0;
        end
      end
      dreq_ready = 1'b0;
      if (dreq_valid && !pend) begin
        if (!seen_req) begin
          seen_req    = 1'b1;
          stall_left  = (force_stall >= 0) ? force_stall : $urandom_range(0, 2);
          saved_addr  = dreq_addr;
          saved_wdata = dreq_wdata;
        end
        if (stall_left > 0) stall_left--;
        else begin
          dreq_ready = 1'b1;
          seen_req   = 1'b0;
          accept_bus();
        end
      end
    end
  end

  // monitor: load results
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (memu_valid === 1'b1) begin
        check("valid_with_ready", 32'(memu_cmd_ready), 32'd1);
        if (exp_q.size() == 0) check("unexpected_memu_valid", 32'(memu_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("load_data", memu_rdata, e);
          last_load = e;
        end
      end
    end
  end

  // direct driver for the no-split DUT: always ready, response one cycle later
  task automatic run_ns(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [31:0] wm, input logic [31:0] rword,
                        output int n_hs, output logic [31:0] f_addr,
                        output logic [3:0] f_strb, output logic [31:0] f_wdata,
                        output logic got_valid, output logic [31:0] rd);
    logic resp_next;
    n_hs = 0; got_valid = 1'b0; rd = 32'b0; resp_next = 1'b0;
    f_addr = 32'b0; f_strb = 4'b0; f_wdata = 32'b0;
    ns_cmd_start = 1'b1; ns_cmd_write = w; ns_addr = a; ns_wdata = wd; ns_wmask = wm;
    @(negedge clk);
    ns_cmd_start = 1'b0; ns_addr = $urandom; ns_wdata = $urandom;
    for (int c = 0; c < 30; c++) begin
      ns_dresp_valid = 1'b0;
      if (resp_next) begin
        ns_dresp_valid = 1'b1;
        ns_dresp_rdata = rword;
        resp_next = 1'b0;
      end else if (ns_dreq_valid) begin
        n_hs++;
        if (n_hs == 1) begin
          f_addr = ns_dreq_addr; f_strb = ns_dreq_wstrb; f_wdata = ns_dreq_wdata;
        end
        resp_next = 1'b1;
      end
      if (ns_valid) begin
        got_valid = 1'b1;
        rd = ns_rdata;
      end
      @(negedge clk);
    end
    ns_dresp_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int          n_hs, cyc;
    logic [31:0] f_addr, f_wdata, rd, a, wm;
    logic [3:0]  f_strb;
    logic        got_valid;

    reset = 1'b1;
    memu_cmd_start = 1'b0; memu_cmd_write = 1'b0;
    memu_addr = 32'b0; memu_wdata = 32'b0; memu_wmask = 32'b0;
    ns_cmd_start = 1'b0; ns_cmd_write = 1'b0;
    ns_addr = 32'b0; ns_wdata = 32'b0; ns_wmask = 32'b0;
    ns_dreq_ready = 1'b1; ns_dresp_valid = 1'b0; ns_dresp_rdata = 32'b0;
    last_load = 32'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", 32'(memu_cmd_ready), 32'd1);
    check("rst_memu_valid", 32'(memu_valid), 32'd0);
    check("rst_memu_rdata", memu_rdata, 32'd0);
    check("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check("rst_dreq_write", 32'(dreq_write), 32'd0);
    check("rst_dreq_addr", dreq_addr, 32'd0);
    check("rst_dreq_wdata", dreq_wdata, 32'd0);
    check("rst_dreq_wstrb", 32'(dreq_wstrb), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // start held during reset must not be taken
    memu_cmd_start = 1'b1; memu_addr = 32'h100;
    @(negedge clk);
    reset = 1'b0; memu_cmd_start = 1'b0;
    check("no_accept_in_reset", 32'(dreq_valid), 32'd0);
    @(negedge clk);
    check("no_accept_in_reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // aligned load with a two-cycle ready stall
    set_word(32'h100, 32'hDEAD_BEEF);
    force_stall = 2;
    issue(32'h100, 1'b0, 32'b0, 32'b0);
    wait_idle();
    force_stall = -1;
    check("aligned_load", memu_rdata, 32'hDEAD_BEEF);

    // misaligned load across two words
    set_word(32'h100, 32'h1122_3344);
    set_word(32'h104, 32'h5566_7788);
    issue(32'h103, 1'b0, 32'b0, 32'b0);
    wait_idle();
    check("misaligned_load", memu_rdata, 32'h6677_8811);

    // byte store, crossing halfword store, wrapping load
    issue(32'h202, 1'b1, 32'h0000_00AB, 32'h0000_00ff);
    issue(32'h1FF, 1'b1, 32'h0000_CDEF, 32'h0000_ffff);
    issue(32'hFFFF_FFFE, 1'b0, 32'b0, 32'b0);
    wait_idle();

    // reset while waiting for the second response
    hold_resp = 1'b1;
    issue(32'h103, 1'b0, 32'b0, 32'b0);
    cyc = 0;
    while (dbg_state != ST_RESP1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_resp1", 32'(dbg_state), 32'(ST_RESP1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    bus_exp_q.delete();
    last_load = 32'b0;
    check("mid_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_reset_valid", 32'(memu_valid), 32'd0);
    check("mid_reset_rdata", memu_rdata, 32'd0);
    hold_resp = 1'b0;
    stray_resp = 1'b1;
    repeat (3) @(negedge clk);
    stray_resp = 1'b0;
    @(negedge clk);
    check("stray_resp_state", 32'(dbg_state), 32'(ST_IDLE));
    check("stray_resp_valid", 32'(memu_valid), 32'd0);

    // randomized back-to-back traffic
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'h100 + 32'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0:       wm = 32'h0000_00ff;
        1:       wm = 32'h0000_ffff;
        2:       wm = 32'hffff_ffff;
        default: wm = $urandom;
      endcase
      issue(a, 1'($urandom_range(0, 1)), $urandom, wm);
    end
    wait_idle();
    check("final_load_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_bus_queue_empty", 32'(bus_exp_q.size()), 32'd0);

    // no-split instance
    run_ns(32'h103, 1'b0, 32'b0, 32'b0, 32'h1122_3344, n_hs, f_addr, f_strb, f_wdata, got_valid, rd);
    check("ns_load_reads", 32'(n_hs), 32'd1);
    check("ns_load_addr", f_addr, 32'h100);
    check("ns_load_valid", 32'(got_valid), 32'd1);
    check("ns_load_data", rd, 32'h0000_0011);
    run_ns(32'h1FF, 1'b1, 32'h0000_CDEF, 32'h0000_ffff, 32'h0, n_hs, f_addr, f_strb, f_wdata, got_valid, rd);
    check("ns_store_writes", 32'(n_hs), 32'd1);
    check("ns_store_addr", f_addr, 32'h1FC);
    check("ns_store_wstrb", 32'(f_strb), 32'h8);
    check("ns_store_wdata", f_wdata & 32'hFF00_0000, 32'hEF00_0000);
    check("ns_store_no_valid", 32'(got_valid), 32'd0);
    check("ns_idle", 32'(ns_cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter SPLIT_MISALIGNED, default 1: 1 = a word-crossing access issues two bus transactions; 0 = only the first word is accessed and bytes beyond it are dropped (read as 0).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 memu_cmd_start  in  1  command request from the memory stage.
REQ-006 memu_cmd_write  in  1  1 = store, 0 = load.
REQ-007 memu_cmd_ready  out  1  unit idle; a command is accepted when this and memu_cmd_start are both high.
REQ-008 memu_addr  in  32  byte address; may be unaligned.
REQ-009 memu_wdata  in  32  store data, low-byte justified.
REQ-010 memu_wmask  in  32  store width: 0x000000ff = 1 byte, 0x0000ffff = 2 bytes, any other value = 4 bytes; loads always fetch 4 bytes.
REQ-011 memu_valid  out  1  one-cycle load-data-valid pulse.
REQ-012 memu_rdata  out  32  load data; the byte at memu_addr is in bits [7:0].
REQ-013 dreq_valid / dreq_ready  out / in  1 / 1  bus request handshake.
REQ-014 dreq_write  out  1  bus write.
REQ-015 dreq_addr  out  32  word address, bits [1:0] always 0.
REQ-016 dreq_wdata  out  32  bus write data.
REQ-017 dreq_wstrb  out  4  bus byte strobes; 0 on reads.
REQ-018 dresp_valid / dresp_rdata  in / in  1 / 32  bus response; one response per request, for both reads and writes.

Function
REQ-019 SHALL implement the FSM states IDLE, REQ0, RESP0, REQ1, RESP1.
REQ-020 memu_cmd_ready SHALL be high exactly when the state is IDLE.
REQ-021 On acceptance, the unit SHALL register the address, write flag, data and size; later changes to these inputs SHALL be ignored until the next acceptance.
REQ-022 The unit SHALL move IDLE->REQ0 on acceptance, and dreq_valid SHALL first be high in the next cycle.
REQ-023 In REQ0 and REQ1, dreq_valid SHALL be high and all dreq_* outputs SHALL be stable until dreq_ready is sampled high; the next state is RESP0 or RESP1 respectively.
REQ-024 In RESP0 and RESP1, the unit SHALL wait for dresp_valid; dreq_valid SHALL be low.
REQ-025 Byte offset and address math: off = addr[1:0]; word0 = {addr[31:2],2'b00}; word1 = word0 + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-026 Store lane mapping: 8-bit strobe = ({0001, 0011, 1111} by size) << off; 64-bit data = wdata << (8*off); word0 uses the low halves, word1 the high halves.
REQ-027 The second transaction is needed for a store when the high strobe nibble is nonzero, and for a load when off != 0; it SHALL be issued only if SPLIT_MISALIGNED = 1.
REQ-028 After dresp_valid in RESP0, the unit SHALL go to REQ1 if the second transaction is needed, else to IDLE; after dresp_valid in RESP1, it SHALL go to IDLE.
REQ-029 Load result = (rdata0 >> 8*off) | (rdata1 << 8*(4-off)); the rdata1 term is 0 when off = 0 or no second transaction occurs.
REQ-030 memu_rdata SHALL be registered; memu_valid SHALL pulse for one cycle, in the cycle after the final dresp_valid of a load, coincident with the return to IDLE.
REQ-031 memu_valid SHALL never assert for stores; store completion is signalled only by memu_cmd_ready returning high.
REQ-032 memu_rdata SHALL hold its value until the next load completes.
REQ-033 dresp_valid SHALL be ignored in IDLE, REQ0 and REQ1.
REQ-034 memu_cmd_start while memu_cmd_ready is low SHALL be ignored.
REQ-035 A new command may be accepted in the same cycle memu_valid is high.

Reset
REQ-036 On reset, the unit SHALL go to state IDLE, with memu_cmd_ready=1, memu_valid=0, memu_rdata=0, dreq_valid=0, dreq_write=0, dreq_addr=0, dreq_wdata=0 and dreq_wstrb=0.
REQ-037 Reset mid-transaction SHALL abandon the access with no memu_valid pulse; any late bus response SHALL be dropped per REQ-033.
REQ-038 memu_cmd_start SHALL NOT be accepted in a cycle where reset is high.

Verification
REQ-039 Aligned load: addr 0x100, bus returns 0xDEADBEEF with 2-cycle dreq_ready stall -> one read at 0x100; memu_valid one cycle; memu_rdata = 0xDEADBEEF.
REQ-040 Misaligned load: addr 0x103, words 0x11223344 / 0x55667788 -> reads at 0x100 then 0x104; memu_rdata = 0x66778811.
REQ-041 Byte store: addr 0x202, wmask 0xff, wdata 0xAB -> one write at 0x200, wstrb 0100, wdata 0x00AB0000; no memu_valid.
REQ-042 Crossing halfword store: addr 0x1FF, wmask 0xffff, wdata 0xCDEF -> write 0x1FC with wstrb 1000 / wdata 0xEF000000, then write 0x200 with wstrb 0001 / wdata 0x000000CD.
REQ-043 Wrap case: load at addr 0xFFFFFFFE -> second read at 0x00000000.
REQ-044 Reset in RESP1 -> state IDLE next cycle, no memu_valid; with SPLIT_MISALIGNED=0, the REQ-040 case gives a single read and memu_rdata = 0x00000011.
